// File: rtl/seg7_seq_checker.sv
// Samples an active-low 7-segment bus on a strobe, decodes it to BCD and tracks the
// decoded stream against a programmed digit sequence, pulsing match on completion.
module seg7_seq_checker #(
    parameter logic [39:0] SEQ     = 40'h0805070857,
    parameter int unsigned SEQ_LEN = 10,
    parameter logic [25:0] TIMEOUT = 26'd50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       seg_stb,
    output logic [3:0] digit,
    output logic       digit_vld,
    output logic       illegal,
    output logic [3:0] pos,
    output logic       match,
    output logic [7:0] match_cnt
);

    typedef enum logic [0:0] {StHunt, StTrack} state_e;

    localparam logic [3:0]  LastPos     = 4'(SEQ_LEN - 1);
    localparam logic [25:0] TimeoutLast = TIMEOUT - 26'd1;

    state_e      state_q, state_d;
    logic [3:0]  digit_q, digit_d;
    logic        vld_q, vld_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  pos_q, pos_d;
    logic        match_q, match_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [25:0] idle_cnt_q, idle_cnt_d;

    logic        dec_ok;
    logic [3:0]  dec_digit;
    logic [3:0]  exp_digit;
    logic [3:0]  seq_digits [10];

    // Digit 0 of the sequence lives in the top nibble.
    for (genvar g = 0; g < 10; g++) begin : g_seq
        assign seq_digits[g] = SEQ[39 - 4 * g -: 4];
    end

    assign exp_digit = seq_digits[pos_q];

    always_comb begin
        dec_ok    = 1'b1;
        dec_digit = 4'd0;
        case (seg_in)
            7'b1000000:              dec_digit = 4'd0;
            7'b1111001:              dec_digit = 4'd1;
            7'b0100100:              dec_digit = 4'd2;
            7'b0110000:              dec_digit = 4'd3;
            7'b0011001:              dec_digit = 4'd4;
            7'b0010010:              dec_digit = 4'd5;
            7'b0000010, 7'b0000011:  dec_digit = 4'd6;
            7'b1111000, 7'b1011000:  dec_digit = 4'd7;
            7'b0000000:              dec_digit = 4'd8;
            7'b0010000, 7'b0011000:  dec_digit = 4'd9;
            default:                 dec_ok    = 1'b0;
        endcase
    end

    always_comb begin
        digit_d     = digit_q;
        vld_d       = 1'b0;
        illegal_d   = 1'b0;
        pos_d       = pos_q;
        match_d     = 1'b0;
        match_cnt_d = match_cnt_q;
        idle_cnt_d  = 26'd0;

        // A strobe always takes priority over an expiring idle counter.
        if (seg_stb) begin
            if (!dec_ok) begin
                illegal_d = 1'b1;
                pos_d     = 4'd0;
            end else begin
                digit_d = dec_digit;
                vld_d   = 1'b1;
                if (dec_digit == exp_digit) begin
                    if (pos_q == LastPos) begin
                        pos_d   = 4'd0;
                        match_d = 1'b1;
                        if (match_cnt_q != 8'hFF) begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end else begin
                    pos_d = (dec_digit == seq_digits[0]) ? 4'd1 : 4'd0;
                end
            end
        end else if (state_q == StTrack) begin
            if (idle_cnt_q == TimeoutLast) begin
                pos_d = 4'd0;
            end else begin
                idle_cnt_d = idle_cnt_q + 26'd1;
            end
        end

        state_d = (pos_d == 4'd0) ? StHunt : StTrack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            digit_q     <= 4'd0;
            vld_q       <= 1'b0;
            illegal_q   <= 1'b0;
            pos_q       <= 4'd0;
            match_q     <= 1'b0;
            match_cnt_q <= 8'd0;
            idle_cnt_q  <= 26'd0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            vld_q       <= vld_d;
            illegal_q   <= illegal_d;
            pos_q       <= pos_d;
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign digit     = digit_q;
    assign digit_vld = vld_q;
    assign illegal   = illegal_q;
    assign pos       = pos_q;
    assign match     = match_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seg7_seq_checker.sv
// Scoreboard bench for seg7_seq_checker: a reference model pushes the expected outputs for
// every driven cycle, and the monitor pops and compares them one cycle later.
module tb_seg7_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       seg_stb;
    logic [3:0] digit;
    logic       digit_vld;
    logic       illegal;
    logic [3:0] pos;
    logic       match;
    logic [7:0] match_cnt;

    always #5 clk = ~clk;

    seg7_seq_checker #(
        .SEQ     (40'h0805070857),
        .SEQ_LEN (10),
        .TIMEOUT (26'd16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .seg_stb   (seg_stb),
        .digit     (digit),
        .digit_vld (digit_vld),
        .illegal   (illegal),
        .pos       (pos),
        .match     (match),
        .match_cnt (match_cnt)
    );

    typedef struct {
        int digit;
        int vld;
        int ill;
        int pos;
        int match;
        int mcnt;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state
    int sq[10] = '{0, 8, 0, 5, 0, 7, 0, 8, 5, 7};
    int m_pos = 0, m_cnt = 0, m_digit = 0, m_mcnt = 0;

    // The test-plan stream (note the alternate 7 pattern 1011000)
    logic [6:0] plan_pat[10] = '{7'b1000000, 7'b0000000, 7'b1000000, 7'b0010010, 7'b1000000,
                                 7'b1011000, 7'b1000000, 7'b0000000, 7'b0010010, 7'b1011000};
    logic [6:0] tbl_pat[14] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b0000011, 7'b1111000, 7'b1011000,
                                7'b0000000, 7'b0010000, 7'b0011000, 7'b1111111};
    int         tbl_dig[14] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 7, 8, 9, 9, -1};

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [6:0] p);
        for (int i = 0; i < 14; i++) begin
            if (tbl_pat[i] == p) return tbl_dig[i];
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic stb, input logic [6:0] p);
        exp_t e;
        int   d;
        exp_t o;
        rst     = r;
        seg_stb = stb;
        seg_in  = p;
        e = '{digit: 0, vld: 0, ill: 0, pos: 0, match: 0, mcnt: 0};
        if (r) begin
            m_pos = 0; m_cnt = 0; m_digit = 0; m_mcnt = 0;
        end else if (stb) begin
            m_cnt = 0;
            d = ref_decode(p);
            if (d < 0) begin
                e.ill = 1;
                m_pos = 0;
            end else begin
                m_digit = d;
                e.vld = 1;
                if (d == sq[m_pos]) begin
                    if (m_pos == 9) begin
                        m_pos = 0;
                        e.match = 1;
                        if (m_mcnt < 255) m_mcnt++;
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_pos = (d == sq[0]) ? 1 : 0;
                end
            end
        end else if (m_pos != 0) begin
            if (m_cnt == 15) begin
                m_pos = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        e.digit = m_digit;
        e.pos   = m_pos;
        e.mcnt  = m_mcnt;
        sb.push_back(e);

        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("digit", int'(digit), o.digit);
        chk("digit_vld", int'(digit_vld), o.vld);
        chk("illegal", int'(illegal), o.ill);
        chk("pos", int'(pos), o.pos);
        chk("match", int'(match), o.match);
        chk("match_cnt", int'(match_cnt), o.mcnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'b1111111);
    endtask

    task automatic send_plan();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, plan_pat[i]);
    endtask

    initial begin
        rst = 1'b1; seg_stb = 1'b0; seg_in = 7'b1111111;
        step(1'b1, 1'b0, 7'b1111111);
        step(1'b1, 1'b0, 7'b1111111);

        // Full sequence on consecutive cycles
        send_plan();
        chk("first_match_cnt", int'(match_cnt), 1);
        idle(2);

        // 4th digit is 3 instead of 5
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, (i == 3) ? 7'b0110000 : plan_pat[i]);
        idle(2);

        // Blank pattern after five good digits
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, plan_pat[i]);
        step(1'b0, 1'b1, 7'b1111111);
        chk("illegal_digit_hold", int'(digit), 0);
        idle(2);

        // Timeout after three digits, then restart
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, plan_pat[i]);
        idle(15);
        chk("timeout_not_yet", int'(pos), 3);
        idle(1);
        chk("timeout_cleared", int'(pos), 0);
        step(1'b0, 1'b1, 7'b1000000);
        chk("restart_pos", int'(pos), 1);
        idle(20);

        // Strobe coinciding with the expiry cycle is evaluated against current pos
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, plan_pat[i]);
        idle(15);
        step(1'b0, 1'b1, 7'b0010010);
        chk("stb_beats_timeout", int'(pos), 4);
        idle(20);

        // Mismatch equal to digit 0
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, plan_pat[i]);
        step(1'b0, 1'b1, 7'b1000000);
        chk("overlap_restart", int'(pos), 1);
        idle(20);

        // Every decode-table entry with the strobe held high, then random patterns
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, tbl_pat[i]);
        for (int i = 0; i < 60; i++) step(1'b0, 1'($urandom_range(0, 1)), 7'($urandom));
        idle(20);

        // Saturation of match_cnt over 256 more back-to-back sequences
        for (int k = 0; k < 256; k++) send_plan();
        chk("match_cnt_sat", int'(match_cnt), 255);

        // Reset mid-sequence
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, plan_pat[i]);
        step(1'b1, 1'b1, plan_pat[4]);
        chk("reset_pos", int'(pos), 0);
        step(1'b0, 1'b1, plan_pat[0]);
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
